// File: rtl/types_pkg.sv
// Shared types for the integer register file: word and index types plus
// the scrub/run state encoding.
package types_pkg;

    localparam int XLEN      = 32;
    localparam int NUM_REGS  = 32;
    localparam int REG_IDX_W = $clog2(NUM_REGS);

    typedef logic [XLEN-1:0]      word_t;
    typedef logic [REG_IDX_W-1:0] reg_index_t;

    typedef enum logic {
        RF_SCRUB,
        RF_RUN
    } rf_state_t;

endpackage

// File: rtl/register_scoreboard.sv
// Per-register pending-write bits with a registered population count.
// A set and a clear to the same register in one cycle leaves it busy.
module register_scoreboard #(
    parameter int SIZE  = 32,
    parameter int IDX_W = $clog2(SIZE)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             set_valid,
    input  logic [IDX_W-1:0] set_idx,
    input  logic             clr_valid,
    input  logic [IDX_W-1:0] clr_idx,
    output logic [SIZE-1:0]  busy,
    output logic [IDX_W:0]   busy_count
);

    logic [SIZE-1:0] busy_next;

    function automatic logic [IDX_W:0] popcount(input logic [SIZE-1:0] v);
        logic [IDX_W:0] n;
        n = '0;
        for (int i = 0; i < SIZE; i++) begin
            n = n + {{IDX_W{1'b0}}, v[i]};
        end
        return n;
    endfunction

    always_comb begin
        busy_next = busy;
        if (clr_valid) begin
            busy_next[clr_idx] = 1'b0;
        end
        if (set_valid) begin
            busy_next[set_idx] = 1'b1;
        end
    end

    // Count follows the bits on the same edge so it never lags the vector.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy       <= '0;
            busy_count <= '0;
        end else begin
            busy       <= busy_next;
            busy_count <= popcount(busy_next);
        end
    end

endmodule

// File: rtl/register_file_scoreboard.sv
// Integer register file with write-through bypass, pending-write scoreboard
// and a post-reset scrub that zeroes every entry before the file reports ready.
module register_file_scoreboard
    import types_pkg::*;
#(
    parameter int SIZE       = 32,
    parameter int WIDTH      = 32,
    parameter int READ_PORTS = 2,
    parameter int ZERO_REG   = 1,
    localparam int IDX_W     = $clog2(SIZE)
) (
    input  logic                                 clk,
    input  logic                                 reset_n,
    output logic                                 ready,
    input  logic [READ_PORTS-1:0][IDX_W-1:0]     rd_addr,
    output logic [READ_PORTS-1:0][WIDTH-1:0]     rd_data,
    output logic [READ_PORTS-1:0]                rd_busy,
    input  logic                                 issue_valid,
    input  logic [IDX_W-1:0]                     issue_rd,
    input  logic                                 wb_valid,
    input  logic [IDX_W-1:0]                     wb_rd,
    input  logic [WIDTH-1:0]                     wb_data,
    output logic [IDX_W:0]                       busy_count
);

    rf_state_t        state, state_next;
    logic [IDX_W-1:0] scrub_idx, scrub_idx_next;
    logic [WIDTH-1:0] regs [SIZE];
    logic [SIZE-1:0]  busy;
    logic             run;
    logic             wb_en;
    logic             issue_en;

    assign run      = (state == RF_RUN);
    assign ready    = run;
    assign wb_en    = run && wb_valid && !((ZERO_REG != 0) && (wb_rd == '0));
    assign issue_en = run && issue_valid && !((ZERO_REG != 0) && (issue_rd == '0));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= RF_SCRUB;
            scrub_idx <= '0;
        end else begin
            state     <= state_next;
            scrub_idx <= scrub_idx_next;
        end
    end

    always_comb begin
        state_next     = state;
        scrub_idx_next = scrub_idx;
        if (state == RF_SCRUB) begin
            scrub_idx_next = scrub_idx + 1'b1;
            if (scrub_idx == IDX_W'(SIZE - 1)) begin
                state_next = RF_RUN;
            end
        end
    end

    // Storage has no reset; the scrub walk is what clears it.
    always_ff @(posedge clk) begin
        if (state == RF_SCRUB) begin
            regs[scrub_idx] <= '0;
        end else if (wb_en) begin
            regs[wb_rd] <= wb_data;
        end
    end

    register_scoreboard #(
        .SIZE  (SIZE),
        .IDX_W (IDX_W)
    ) u_scoreboard (
        .clk        (clk),
        .reset_n    (reset_n),
        .set_valid  (issue_en),
        .set_idx    (issue_rd),
        .clr_valid  (wb_en),
        .clr_idx    (wb_rd),
        .busy       (busy),
        .busy_count (busy_count)
    );

    logic [READ_PORTS-1:0] hit_zero;
    logic [READ_PORTS-1:0] hit_wb;

    // A bypassed read sees the incoming value; its busy reflects only a
    // same-cycle re-reservation, since the writeback retires the old one.
    for (genvar p = 0; p < READ_PORTS; p++) begin : g_read
        assign hit_zero[p] = (ZERO_REG != 0) && (rd_addr[p] == '0);
        assign hit_wb[p]   = wb_en && (wb_rd == rd_addr[p]);
        assign rd_data[p]  = (!run || hit_zero[p]) ? '0 :
                             hit_wb[p]             ? wb_data :
                                                     regs[rd_addr[p]];
        assign rd_busy[p]  = (!run || hit_zero[p]) ? 1'b0 :
                             hit_wb[p]             ? (issue_en && (issue_rd == rd_addr[p])) :
                                                     busy[rd_addr[p]];
    end

endmodule

// File: tb/tb_register_file_scoreboard.sv
// Bench for register_file_scoreboard: directed scenarios plus random traffic,
// checked against an array/bit-vector model of the file.
module tb_register_file_scoreboard;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             ready;
    logic [1:0][4:0]  rd_addr;
    logic [1:0][31:0] rd_data;
    logic [1:0]       rd_busy;
    logic             issue_valid;
    logic [4:0]       issue_rd;
    logic             wb_valid;
    logic [4:0]       wb_rd;
    logic [31:0]      wb_data;
    logic [5:0]       busy_count;

    int checks = 0;
    int errors = 0;

    logic [31:0] mdl_x [32];
    logic [31:0] mdl_busy;
    logic        mdl_ready;
    int          mdl_scrub_cycles;

    always #5 clk = ~clk;

    register_file_scoreboard #(
        .SIZE       (32),
        .WIDTH      (32),
        .READ_PORTS (2),
        .ZERO_REG   (1)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .ready       (ready),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .rd_busy     (rd_busy),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .wb_valid    (wb_valid),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .busy_count  (busy_count)
    );

    task automatic chk(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] exp_data(input logic [4:0] a);
        if (!mdl_ready || a == 5'd0) return 32'd0;
        if (wb_valid && wb_rd == a) return wb_data;
        return mdl_x[a];
    endfunction

    function automatic logic exp_busy(input logic [4:0] a);
        if (!mdl_ready || a == 5'd0) return 1'b0;
        if (wb_valid && wb_rd == a) return issue_valid && issue_rd == a;
        return mdl_busy[a];
    endfunction

    task automatic model_reset();
        mdl_busy         = '0;
        mdl_ready        = 1'b0;
        mdl_scrub_cycles = 0;
        for (int i = 0; i < 32; i++) mdl_x[i] = '0;
    endtask

    task automatic model_edge();
        if (!mdl_ready) begin
            mdl_scrub_cycles++;
            if (mdl_scrub_cycles == 32) mdl_ready = 1'b1;
        end else begin
            if (wb_valid && wb_rd != 5'd0) begin
                mdl_x[wb_rd]    = wb_data;
                mdl_busy[wb_rd] = 1'b0;
            end
            if (issue_valid && issue_rd != 5'd0) mdl_busy[issue_rd] = 1'b1;
        end
    endtask

    task automatic step(input logic iv, input logic [4:0] ir, input logic wv, input logic [4:0] wr,
                        input logic [31:0] wd, input logic [4:0] a0, input logic [4:0] a1);
        issue_valid = iv;
        issue_rd    = ir;
        wb_valid    = wv;
        wb_rd       = wr;
        wb_data     = wd;
        rd_addr[0]  = a0;
        rd_addr[1]  = a1;
        #1;
        for (int p = 0; p < 2; p++) begin
            chk($sformatf("rd_data%0d@r%0d", p, rd_addr[p]), 64'(rd_data[p]), 64'(exp_data(rd_addr[p])));
            chk($sformatf("rd_busy%0d@r%0d", p, rd_addr[p]), 64'(rd_busy[p]), 64'(exp_busy(rd_addr[p])));
        end
        chk("ready", 64'(ready), 64'(mdl_ready));
        chk("busy_count", 64'(busy_count), 64'($countones(mdl_busy)));
        @(posedge clk);
        if (reset_n) model_edge();
        #1;
    endtask

    task automatic idle(input logic [4:0] a0, input logic [4:0] a1);
        step(1'b0, 5'd0, 1'b0, 5'd0, 32'd0, a0, a1);
    endtask

    task automatic rand_step(input int addr_hi);
        step(1'($urandom), 5'($urandom_range(0, addr_hi)), 1'($urandom), 5'($urandom_range(0, addr_hi)),
             $urandom, 5'($urandom_range(0, addr_hi)), 5'($urandom_range(0, addr_hi)));
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        #1;
        model_reset();
        chk("reset_ready", 64'(ready), 64'd0);
        chk("reset_busy_count", 64'(busy_count), 64'd0);
        chk("reset_rd_busy", 64'(rd_busy), 64'd0);
        chk("reset_rd_data", 64'(rd_data[0]), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n     = 1'b1;
        issue_valid = 1'b0;
        issue_rd    = '0;
        wb_valid    = 1'b0;
        wb_rd       = '0;
        wb_data     = '0;
        rd_addr     = '0;
        model_reset();
        @(posedge clk);
        #1;
        apply_reset();

        // Scrub window: random traffic must have no effect; ready only after 32 edges.
        repeat (32) rand_step(31);
        chk("ready_after_scrub", 64'(ready), 64'd1);

        // Bypass of a writeback into a same-cycle read, then the array copy.
        step(1'b0, 5'd0, 1'b1, 5'd5, 32'hDEAD_BEEF, 5'd5, 5'd4);
        idle(5'd5, 5'd0);

        // Register zero ignores writes and reservations.
        step(1'b0, 5'd0, 1'b1, 5'd0, 32'h1234, 5'd0, 5'd0);
        step(1'b1, 5'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd5);
        idle(5'd0, 5'd0);

        // Reserve r7, retire it with 42.
        step(1'b1, 5'd7, 1'b0, 5'd0, 32'd0, 5'd7, 5'd0);
        idle(5'd7, 5'd5);
        step(1'b0, 5'd0, 1'b1, 5'd7, 32'd42, 5'd7, 5'd7);
        idle(5'd7, 5'd0);

        // Same-cycle reserve and writeback of r9 leaves it busy with the new data.
        step(1'b1, 5'd9, 1'b1, 5'd9, 32'h0000_9999, 5'd9, 5'd7);
        idle(5'd9, 5'd9);
        step(1'b0, 5'd0, 1'b1, 5'd9, 32'h0000_0009, 5'd9, 5'd0);
        step(1'b1, 5'd9, 1'b0, 5'd0, 32'd0, 5'd9, 5'd0);
        step(1'b1, 5'd9, 1'b0, 5'd0, 32'd0, 5'd9, 5'd0);
        step(1'b0, 5'd0, 1'b1, 5'd9, 32'h0000_0019, 5'd9, 5'd9);
        idle(5'd9, 5'd7);

        // Dense random traffic over a few registers, then over the whole file.
        repeat (200) rand_step(7);
        repeat (200) rand_step(31);

        // Fill every register's busy bit to exercise the counter ceiling.
        for (int r = 0; r < 32; r++) step(1'b1, 5'(r), 1'b0, 5'd0, 32'd0, 5'(r), 5'd0);
        idle(5'd31, 5'd1);
        chk("busy_count_ceiling", 64'(busy_count), 64'd31);
        for (int r = 0; r < 32; r++) step(1'b0, 5'd0, 1'b1, 5'(r), $urandom, 5'(r), 5'($urandom_range(0, 31)));

        // r3 holds 77 and is busy when reset hits mid-run.
        step(1'b0, 5'd0, 1'b1, 5'd3, 32'd77, 5'd3, 5'd0);
        step(1'b1, 5'd3, 1'b0, 5'd0, 32'd0, 5'd3, 5'd0);
        idle(5'd3, 5'd3);
        apply_reset();
        repeat (32) rand_step(31);
        idle(5'd3, 5'd3);
        chk("r3_after_rescrub", 64'(rd_data[0]), 64'd0);
        repeat (50) rand_step(15);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
